// File: rtl/ysyx_22040127_mem_arbiter_if.sv
// Request/response channel shared by the fetch, data and downstream memory ports.
// On the downstream channel gnt carries m_ready and bvalid carries the write response.
interface ysyx_22040127_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  req;
  logic                  we;
  logic                  flush;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  bvalid;

  modport master (
    output req, we, flush, addr, wdata, wmask,
    input  gnt, rvalid, rdata, bvalid
  );

  modport slave (
    input  req, we, flush, addr, wdata, wmask,
    output gnt, rvalid, rdata, bvalid
  );
endinterface

// File: rtl/ysyx_22040127_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (I) and data (D).
// D has priority; after STARVE_MAX D grants with a fetch pending, I is forced through.
//
// state  | meaning
// IDLE   | no transaction outstanding; the only state that issues m_req
// I_WAIT | fetch read granted, waiting for m_rvalid
// D_RD   | data load granted, waiting for m_rvalid
// D_WR   | data store granted, waiting for m_bvalid
module ysyx_22040127_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  ysyx_22040127_mem_arbiter_if.slave  i_bus,
  ysyx_22040127_mem_arbiter_if.slave  d_bus,
  ysyx_22040127_mem_arbiter_if.master m_bus,
  output logic busy,
  output logic owner
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_WAIT = 2'd1;
  localparam logic [1:0] D_RD   = 2'd2;
  localparam logic [1:0] D_WR   = 2'd3;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] starve_cnt;
  logic             flush_pending;
  logic             d_win, i_win, grant;
  logic             is_idle;

  assign is_idle = (state == IDLE);

  always_comb begin
    d_win = d_bus.req && !(i_bus.req && (starve_cnt == STARVE_TOP));
    i_win = i_bus.req && !d_win;
  end

  // rst gates m_req so nothing leaks downstream while reset is held
  assign m_bus.req   = rst && is_idle && (i_bus.req || d_bus.req);
  assign grant       = m_bus.req && m_bus.gnt;
  assign i_bus.gnt   = grant && i_win;
  assign d_bus.gnt   = grant && d_win;

  assign m_bus.addr  = d_win ? d_bus.addr : i_bus.addr;
  assign m_bus.we    = d_win && d_bus.we;
  assign m_bus.wdata = d_win ? d_bus.wdata : '0;
  assign m_bus.wmask = (d_win && d_bus.we) ? d_bus.wmask : '0;
  assign m_bus.flush = 1'b0;

  assign i_bus.rdata  = m_bus.rdata;
  assign d_bus.rdata  = m_bus.rdata;
  assign i_bus.rvalid = (state == I_WAIT) && m_bus.rvalid && !flush_pending && !i_bus.flush;
  assign d_bus.rvalid = (state == D_RD) && m_bus.rvalid;
  assign d_bus.bvalid = (state == D_WR) && m_bus.bvalid;
  assign i_bus.bvalid = 1'b0;

  assign busy = !is_idle;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (grant) state_nx = d_win ? (d_bus.we ? D_WR : D_RD) : I_WAIT;
      I_WAIT: if (m_bus.rvalid) state_nx = IDLE;
      D_RD:   if (m_bus.rvalid) state_nx = IDLE;
      D_WR:   if (m_bus.bvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      flush_pending <= 1'b0;
      owner         <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) owner <= d_win;

      if (!i_bus.req || i_bus.gnt)
        starve_cnt <= '0;
      else if (d_bus.gnt && (starve_cnt != STARVE_TOP))
        starve_cnt <= starve_cnt + 1'b1;

      if (state == I_WAIT)
        flush_pending <= m_bus.rvalid ? 1'b0 : (flush_pending || i_bus.flush);
      else
        flush_pending <= i_bus.gnt && i_bus.flush;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{d_bus.flush, i_bus.we, i_bus.wdata, i_bus.wmask};
endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// Self-checking bench for the memory arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_ysyx_22040127_mem_arbiter;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, owner;
  int   checks = 0;
  int   errors = 0;

  ysyx_22040127_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ib ();
  ysyx_22040127_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) db ();
  ysyx_22040127_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) mb ();

  ysyx_22040127_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .i_bus(ib), .d_bus(db), .m_bus(mb), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ib.req = 0; ib.addr = '0; ib.flush = 0; ib.we = 0; ib.wdata = '0; ib.wmask = '0;
    db.req = 0; db.addr = '0; db.flush = 0; db.we = 0; db.wdata = '0; db.wmask = '0;
    mb.gnt = 0; mb.rvalid = 0; mb.rdata = '0; mb.bvalid = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ib.req = 1; db.req = 1; mb.gnt = 1; mb.rvalid = 1; mb.bvalid = 1;
    @(negedge clk);
    checks++; if (mb.req !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b exp 0", mb.req); end
    checks++; if ({ib.gnt, db.gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {ib.gnt, db.gnt}); end
    checks++; if ({ib.rvalid, db.rvalid, db.bvalid} !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", {ib.rvalid, db.rvalid, db.bvalid}); end
    checks++; if ({busy, owner} !== 2'b00) begin errors++; $display("FAIL reset_busy_owner got %b exp 00", {busy, owner}); end
    next_cycle();
    idle_inputs();
    rst = 1;
    next_cycle();
  endtask

  task automatic test_fetch();
    ib.req = 1; ib.addr = 64'h8000_0000; mb.gnt = 1;
    @(negedge clk);
    checks++; if ({mb.req, ib.gnt, db.gnt} !== 3'b110) begin errors++; $display("FAIL fetch_gnt got %b exp 110", {mb.req, ib.gnt, db.gnt}); end
    checks++; if (mb.addr !== 64'h8000_0000) begin errors++; $display("FAIL fetch_addr got %h exp 80000000", mb.addr); end
    checks++; if ({mb.we, mb.wmask} !== 9'h0) begin errors++; $display("FAIL fetch_we_mask got %h exp 0", {mb.we, mb.wmask}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_busy0 got %b exp 0", busy); end
    next_cycle();
    ib.req = 0; mb.gnt = 0;
    @(negedge clk);
    checks++; if ({busy, ib.rvalid, mb.req} !== 3'b100) begin errors++; $display("FAIL fetch_wait got %b exp 100", {busy, ib.rvalid, mb.req}); end
    next_cycle();
    mb.rvalid = 1; mb.rdata = 64'h0000_0013_0000_0093;
    @(negedge clk);
    checks++; if ({busy, ib.rvalid} !== 2'b11) begin errors++; $display("FAIL fetch_rvalid got %b exp 11", {busy, ib.rvalid}); end
    checks++; if (ib.rdata !== 64'h0000_0013_0000_0093) begin errors++; $display("FAIL fetch_rdata got %h exp 0000001300000093", ib.rdata); end
    next_cycle();
    mb.rvalid = 0;
    @(negedge clk);
    checks++; if ({busy, owner} !== 2'b00) begin errors++; $display("FAIL fetch_done got %b exp 00", {busy, owner}); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    ib.req = 1; ib.addr = 64'h8000_0040; db.req = 1; db.we = 0; db.addr = 64'h8000_1000; mb.gnt = 1;
    @(negedge clk);
    checks++; if ({ib.gnt, db.gnt} !== 2'b01) begin errors++; $display("FAIL simul_first got %b exp 01", {ib.gnt, db.gnt}); end
    checks++; if (mb.addr !== 64'h8000_1000) begin errors++; $display("FAIL simul_daddr got %h exp 80001000", mb.addr); end
    next_cycle();
    db.req = 0; mb.rvalid = 1; mb.rdata = 64'hdead_beef_0bad_f00d;
    @(negedge clk);
    checks++; if ({busy, owner, mb.req, ib.gnt} !== 4'b1100) begin errors++; $display("FAIL simul_drd got %b exp 1100", {busy, owner, mb.req, ib.gnt}); end
    checks++; if ({db.rvalid, ib.rvalid, db.rdata == 64'hdead_beef_0bad_f00d} !== 3'b101) begin errors++; $display("FAIL simul_dresp got %b exp 101", {db.rvalid, ib.rvalid, db.rdata == 64'hdead_beef_0bad_f00d}); end
    next_cycle();
    mb.rvalid = 0;
    @(negedge clk);
    checks++; if ({ib.gnt, db.gnt, busy} !== 3'b100) begin errors++; $display("FAIL simul_igrant got %b exp 100", {ib.gnt, db.gnt, busy}); end
    checks++; if (mb.addr !== 64'h8000_0040) begin errors++; $display("FAIL simul_iaddr got %h exp 80000040", mb.addr); end
    next_cycle();
    ib.req = 0; mb.gnt = 0; mb.rvalid = 1;
    @(negedge clk);
    checks++; if ({ib.rvalid, owner} !== 2'b10) begin errors++; $display("FAIL simul_iresp got %b exp 10", {ib.rvalid, owner}); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_starvation();
    int grants = 0, dgrants = 0, igrant_at = 0;
    bit seen = 0;
    ib.req = 1; ib.addr = 64'h8000_0100; db.req = 1; db.we = 0; db.addr = 64'h8000_2000;
    mb.gnt = 1; mb.rvalid = 1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (db.gnt) begin grants++; dgrants++; end
      if (ib.gnt) begin grants++; igrant_at = grants; seen = 1; end
      next_cycle();
    end
    checks++; if (!seen) begin errors++; $display("FAIL starve_timeout got no i_gnt exp i_gnt within 20 cycles"); end
    checks++; if (dgrants !== SMAX) begin errors++; $display("FAIL starve_dcount got %0d exp %0d", dgrants, SMAX); end
    checks++; if (igrant_at !== SMAX + 1) begin errors++; $display("FAIL starve_igrant_pos got %0d exp %0d", igrant_at, SMAX + 1); end
    checks++; if (dut.starve_cnt !== '0) begin errors++; $display("FAIL starve_cnt_clear got %0d exp 0", dut.starve_cnt); end
    ib.req = 0; db.req = 0;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_store();
    db.req = 1; db.we = 1; db.addr = 64'h8000_3000; db.wmask = 8'h0F; db.wdata = 64'h1122_3344; mb.gnt = 1;
    @(negedge clk);
    checks++; if ({db.gnt, mb.we, mb.wmask} !== 10'b11_0000_1111) begin errors++; $display("FAIL store_grant got %b exp 1100001111", {db.gnt, mb.we, mb.wmask}); end
    checks++; if (mb.wdata !== 64'h1122_3344) begin errors++; $display("FAIL store_wdata got %h exp 11223344", mb.wdata); end
    next_cycle();
    db.req = 0; mb.rvalid = 1;
    @(negedge clk);
    checks++; if ({busy, db.rvalid, db.bvalid, ib.rvalid} !== 4'b1000) begin errors++; $display("FAIL store_stray got %b exp 1000", {busy, db.rvalid, db.bvalid, ib.rvalid}); end
    next_cycle();
    mb.rvalid = 0; mb.bvalid = 1;
    @(negedge clk);
    checks++; if ({busy, db.bvalid} !== 2'b11) begin errors++; $display("FAIL store_bdone got %b exp 11", {busy, db.bvalid}); end
    next_cycle();
    mb.bvalid = 0;
    @(negedge clk);
    checks++; if ({busy, owner} !== 2'b01) begin errors++; $display("FAIL store_idle got %b exp 01", {busy, owner}); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_flush();
    ib.req = 1; ib.addr = 64'h8000_0200; mb.gnt = 1;
    @(negedge clk);
    checks++; if (ib.gnt !== 1'b1) begin errors++; $display("FAIL flush_grant got %b exp 1", ib.gnt); end
    next_cycle();
    ib.req = 0; ib.flush = 1;
    next_cycle();
    ib.flush = 0;
    next_cycle();
    mb.rvalid = 1;
    @(negedge clk);
    checks++; if ({busy, ib.rvalid} !== 2'b10) begin errors++; $display("FAIL flush_suppress got %b exp 10", {busy, ib.rvalid}); end
    next_cycle();
    mb.rvalid = 0; db.req = 1; db.we = 0; db.addr = 64'h8000_4000;
    @(negedge clk);
    checks++; if ({busy, db.gnt} !== 2'b01) begin errors++; $display("FAIL flush_next_d got %b exp 01", {busy, db.gnt}); end
    next_cycle();
    db.req = 0; mb.rvalid = 1;
    @(negedge clk);
    checks++; if (db.rvalid !== 1'b1) begin errors++; $display("FAIL flush_d_resp got %b exp 1", db.rvalid); end
    next_cycle();
    mb.rvalid = 0; ib.req = 1;
    @(negedge clk);
    checks++; if (ib.gnt !== 1'b1) begin errors++; $display("FAIL flush_coinc_grant got %b exp 1", ib.gnt); end
    next_cycle();
    ib.req = 0; ib.flush = 1; mb.rvalid = 1;
    @(negedge clk);
    checks++; if ({busy, ib.rvalid} !== 2'b10) begin errors++; $display("FAIL flush_coincident got %b exp 10", {busy, ib.rvalid}); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_coinc_idle got %b exp 0", busy); end
    next_cycle();
  endtask

  task automatic test_backpressure_reset();
    ib.req = 1; ib.addr = 64'h8000_0300; mb.gnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({mb.req, ib.gnt, busy} !== 3'b100) begin errors++; $display("FAIL bp_hold%0d got %b exp 100", c, {mb.req, ib.gnt, busy}); end
      next_cycle();
    end
    mb.gnt = 1;
    @(negedge clk);
    checks++; if (ib.gnt !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", ib.gnt); end
    next_cycle();
    ib.req = 0; mb.gnt = 0; db.req = 1; db.addr = 64'h8000_5000;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_iwait got %b exp 1", busy); end
    next_cycle();
    rst = 0;
    #1;
    checks++; if ({busy, owner, mb.req, db.gnt, ib.rvalid} !== 5'b0) begin errors++; $display("FAIL rst_async got %b exp 00000", {busy, owner, mb.req, db.gnt, ib.rvalid}); end
    checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dut.state); end
    next_cycle();
    rst = 1; db.req = 0; mb.rvalid = 1;
    @(negedge clk);
    checks++; if ({ib.rvalid, busy} !== 2'b00) begin errors++; $display("FAIL rst_drop_resp got %b exp 00", {ib.rvalid, busy}); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  // Transaction-level model: pend names the outstanding transaction (0 none, 1 fetch,
  // 2 load, 3 store); passed counts D grants taken while a fetch was waiting.
  task automatic test_random();
    int pend = 0, passed = 0;
    bit ffl = 0, exp_owner = 0, ig = 0, dg = 0;
    bit exp_mreq, d_first, e_ig, e_dg, e_irv, e_drv, e_bd, resp;
    for (int c = 0; c < 600; c++) begin
      if (ig) ib.req = 0;
      if (dg) db.req = 0;
      if (!ib.req && $urandom_range(0, 2) == 0) begin ib.req = 1; ib.addr = {32'h0, $urandom}; end
      if (!db.req && $urandom_range(0, 2) == 0) begin
        db.req = 1; db.we = 1'($urandom_range(0, 1)); db.addr = {$urandom, $urandom};
        db.wdata = {$urandom, $urandom}; db.wmask = 8'($urandom_range(0, 255));
      end
      ib.flush  = ($urandom_range(0, 7) == 0);
      mb.gnt    = ($urandom_range(0, 3) != 0);
      mb.rvalid = ($urandom_range(0, 2) == 0);
      mb.bvalid = ($urandom_range(0, 2) == 0);
      mb.rdata  = {$urandom, $urandom};
      @(negedge clk);
      exp_mreq = (pend == 0) && (ib.req || db.req);
      d_first  = db.req && !(ib.req && passed >= SMAX);
      e_dg  = exp_mreq && mb.gnt && d_first;
      e_ig  = exp_mreq && mb.gnt && ib.req && !d_first;
      e_irv = (pend == 1) && mb.rvalid && !ffl && !ib.flush;
      e_drv = (pend == 2) && mb.rvalid;
      e_bd  = (pend == 3) && mb.bvalid;
      checks++; if ({mb.req, ib.gnt, db.gnt} !== {exp_mreq, e_ig, e_dg}) begin errors++; $display("FAIL rnd_grant c%0d got %b exp %b", c, {mb.req, ib.gnt, db.gnt}, {exp_mreq, e_ig, e_dg}); end
      checks++; if ({ib.rvalid, db.rvalid, db.bvalid} !== {e_irv, e_drv, e_bd}) begin errors++; $display("FAIL rnd_resp c%0d got %b exp %b", c, {ib.rvalid, db.rvalid, db.bvalid}, {e_irv, e_drv, e_bd}); end
      checks++; if ({busy, owner} !== {pend != 0, exp_owner}) begin errors++; $display("FAIL rnd_busy_owner c%0d got %b exp %b", c, {busy, owner}, {pend != 0, exp_owner}); end
      checks++; if ({ib.rdata, db.rdata} !== {mb.rdata, mb.rdata}) begin errors++; $display("FAIL rnd_rdata c%0d got %h exp %h", c, ib.rdata, mb.rdata); end
      if (exp_mreq) begin
        checks++;
        if (mb.addr !== (d_first ? db.addr : ib.addr) || mb.we !== (d_first && db.we) ||
            mb.wmask !== ((d_first && db.we) ? db.wmask : 8'h00)) begin
          errors++; $display("FAIL rnd_payload c%0d got %h/%b/%h", c, mb.addr, mb.we, mb.wmask);
        end
      end
      ig = e_ig; dg = e_dg;
      resp = (pend == 1 || pend == 2) ? mb.rvalid : (pend == 3) ? mb.bvalid : 1'b0;
      if (pend == 1 && !resp && ib.flush) ffl = 1;
      if (resp) begin pend = 0; ffl = 0; end
      if (e_ig) begin pend = 1; ffl = ib.flush; passed = 0; exp_owner = 0; end
      if (e_dg) begin
        pend = db.we ? 3 : 2; exp_owner = 1;
        if (ib.req && passed < SMAX) passed++;
      end
      if (!ib.req) passed = 0;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_flush();
    test_backpressure_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
